// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT/INTT address sequencer.
package ntt_pkg;

   localparam int unsigned MAX_LOG_N = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } ntt_ag_state_t;

   function automatic logic [31:0] ntt_len(input int unsigned log_n);
      return 32'd1 << log_n;
   endfunction

   // Open a zero at bit p of j: bits below p stay, bits at and above p move up one.
   function automatic logic [31:0] insert_zero(input logic [31:0] j, input logic [31:0] p);
      logic [31:0] low_mask;
      low_mask = (32'd1 << p) - 32'd1;
      return ((j & ~low_mask) << 1) | (j & low_mask);
   endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Valid+data shift register that replays read addresses as write addresses.
module ntt_delay_line #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         any_valid,
   output logic         early_valid
);

   logic [DEPTH-1:0] v;
   logic [W-1:0]     d [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= '0;
         for (int i = 0; i < DEPTH; i++) d[i] <= '0;
      end else begin
         v[0] <= in_valid;
         d[0] <= in_data;
         for (int i = 1; i < DEPTH; i++) begin
            v[i] <= v[i-1];
            d[i] <= d[i-1];
         end
      end
   end

   // any_valid: something is still in flight after the tail's current write.
   // early_valid: same, but also ignoring the entry that becomes the tail next.
   always_comb begin
      any_valid   = 1'b0;
      early_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((i + 1 < DEPTH) && v[i]) any_valid = 1'b1;
         if ((i + 2 < DEPTH) && v[i]) early_valid = 1'b1;
      end
   end

   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

endmodule

// File: rtl/ntt_addr_gen_v2.sv
// In-place NTT/INTT butterfly address sequencer with twiddle indices and
// write-address replay after a fixed butterfly-pipeline latency.
module ntt_addr_gen_v2
   import ntt_pkg::*;
#(
   parameter int unsigned LOG_N       = 8,
   parameter int unsigned PIPE_DELAY  = 11,
   parameter bit          STAGE_FLUSH = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         inverse,
   input  logic                         advance,
   output logic [LOG_N-1:0]             rd_addr,
   output logic                         rd_valid,
   output logic [LOG_N-1:0]             tw_addr,
   output logic [LOG_N-1:0]             wr_addr,
   output logic                         wr_valid,
   output logic [$clog2(LOG_N+1)-1:0]   stage,
   output logic                         busy,
   output logic                         done,
   output ntt_ag_state_t                fsm_state
);

   localparam int unsigned SW     = $clog2(LOG_N + 1);
   localparam int unsigned N      = ntt_len(LOG_N);
   localparam int unsigned HALF_N = N / 2;
   localparam logic [LOG_N-2:0] J_LAST = (LOG_N-1)'(HALF_N - 1);

   ntt_ag_state_t state, next_state;

   logic [LOG_N-2:0] j;
   logic             phase;
   logic             inverse_q;
   logic [SW-1:0]    pivot;
   logic [LOG_N-1:0] lower, upper, tw_next;
   logic             last_j, last_stage, stage_end;
   logic             line_any, line_early;
   logic             flush_clear, drain_clear;

   // Forward walks the pivot MSB->LSB, inverse LSB->MSB.
   assign pivot   = inverse_q ? stage : (SW'(LOG_N - 1) - stage);
   assign lower   = LOG_N'(insert_zero(32'(j), 32'(pivot)));
   assign upper   = lower | (LOG_N'(1) << pivot);
   assign tw_next = LOG_N'((32'd1 << (32'(LOG_N - 1) - 32'(pivot))) + (32'(j) >> pivot));

   assign last_j     = (j == J_LAST);
   assign last_stage = (stage == SW'(LOG_N - 1));
   assign stage_end  = (state == ST_ISSUE) && advance && phase && last_j;

   // The first read of the next stage registers one edge after FLUSH exits,
   // so FLUSH may leave while the final entry is one slot from the tail.
   assign flush_clear = (PIPE_DELAY < 2) ? 1'b1 : (!rd_valid && !line_early);
   assign drain_clear = !rd_valid && !line_any;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (start) next_state = ST_ISSUE;
         ST_ISSUE: begin
            if (stage_end) begin
               if (last_stage)       next_state = ST_DRAIN;
               else if (STAGE_FLUSH) next_state = ST_FLUSH;
            end
         end
         ST_FLUSH: if (flush_clear) next_state = ST_ISSUE;
         ST_DRAIN: if (drain_clear) next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr   <= '0;
         rd_valid  <= 1'b0;
         tw_addr   <= '0;
         stage     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         j         <= '0;
         phase     <= 1'b0;
         inverse_q <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  inverse_q <= inverse;
                  j         <= '0;
                  phase     <= 1'b0;
                  stage     <= '0;
                  busy      <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (advance) begin
                  rd_valid <= 1'b1;
                  rd_addr  <= phase ? upper : lower;
                  tw_addr  <= tw_next;
                  phase    <= ~phase;
                  if (phase) begin
                     j <= j + 1'b1;
                     if (last_j && !last_stage && !STAGE_FLUSH) stage <= stage + 1'b1;
                  end
               end
            end
            ST_FLUSH: if (flush_clear) stage <= stage + 1'b1;
            ST_DRAIN: begin
               if (drain_clear) begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   ntt_delay_line #(
      .W     (int'(LOG_N)),
      .DEPTH (int'(PIPE_DELAY))
   ) u_delay (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (rd_valid),
      .in_data     (rd_addr),
      .out_valid   (wr_valid),
      .out_data    (wr_addr),
      .any_valid   (line_any),
      .early_valid (line_early)
   );

   assign fsm_state = state;

endmodule

// File: tb/tb_ntt_addr_gen_v2.sv
// Bench for ntt_addr_gen_v2 at LOG_N=3, PIPE_DELAY=4 with and without stage flush.
module tb_ntt_addr_gen_v2;
   import ntt_pkg::*;

   localparam int LOG_N = 3;
   localparam int PD    = 4;
   localparam int NREAD = 24;

   typedef struct packed {
      logic       inv;
      logic [1:0] stg;
      logic [2:0] rd;
      logic [2:0] tw;
   } vec_t;

   logic clk = 1'b0;
   logic rst, start, inverse, advance;

   logic [2:0] nf_rd_addr, nf_tw_addr, nf_wr_addr, fl_rd_addr, fl_tw_addr, fl_wr_addr;
   logic       nf_rd_valid, nf_wr_valid, nf_busy, nf_done;
   logic       fl_rd_valid, fl_wr_valid, fl_busy, fl_done;
   logic [1:0] nf_stage, fl_stage;
   ntt_ag_state_t nf_state, fl_state;

   logic       sel = 1'b0;
   logic [2:0] m_rd_addr, m_tw_addr, m_wr_addr;
   logic       m_rd_valid, m_wr_valid, m_busy, m_done;
   logic [1:0] m_stage;
   ntt_ag_state_t m_state;

   ntt_addr_gen_v2 #(.LOG_N(LOG_N), .PIPE_DELAY(PD), .STAGE_FLUSH(1'b0)) u_nf (
      .clk(clk), .rst(rst), .start(start), .inverse(inverse), .advance(advance),
      .rd_addr(nf_rd_addr), .rd_valid(nf_rd_valid), .tw_addr(nf_tw_addr),
      .wr_addr(nf_wr_addr), .wr_valid(nf_wr_valid), .stage(nf_stage),
      .busy(nf_busy), .done(nf_done), .fsm_state(nf_state)
   );

   ntt_addr_gen_v2 #(.LOG_N(LOG_N), .PIPE_DELAY(PD), .STAGE_FLUSH(1'b1)) u_fl (
      .clk(clk), .rst(rst), .start(start), .inverse(inverse), .advance(advance),
      .rd_addr(fl_rd_addr), .rd_valid(fl_rd_valid), .tw_addr(fl_tw_addr),
      .wr_addr(fl_wr_addr), .wr_valid(fl_wr_valid), .stage(fl_stage),
      .busy(fl_busy), .done(fl_done), .fsm_state(fl_state)
   );

   assign m_rd_addr  = sel ? fl_rd_addr  : nf_rd_addr;
   assign m_tw_addr  = sel ? fl_tw_addr  : nf_tw_addr;
   assign m_wr_addr  = sel ? fl_wr_addr  : nf_wr_addr;
   assign m_rd_valid = sel ? fl_rd_valid : nf_rd_valid;
   assign m_wr_valid = sel ? fl_wr_valid : nf_wr_valid;
   assign m_busy     = sel ? fl_busy     : nf_busy;
   assign m_done     = sel ? fl_done     : nf_done;
   assign m_stage    = sel ? fl_stage    : nf_stage;
   assign m_state    = sel ? fl_state    : nf_state;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int adv_mode = 0;
   always @(posedge clk) begin
      #1;
      advance = (adv_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // ---------------- reference tables ----------------
   int fwd_rd [NREAD] = '{0,4,1,5,2,6,3,7, 0,2,1,3,4,6,5,7, 0,1,2,3,4,5,6,7};
   int fwd_tw [12]    = '{1,1,1,1, 2,2,3,3, 4,5,6,7};
   int inv_rd [NREAD] = '{0,1,2,3,4,5,6,7, 0,2,1,3,4,6,5,7, 0,4,1,5,2,6,3,7};
   int inv_tw [12]    = '{4,5,6,7, 2,2,3,3, 1,1,1,1};
   vec_t tab [2][NREAD];

   // ---------------- scoreboard ----------------
   logic [34:0] exp_q[$];
   int   total = 0, bad = 0;
   int   idx = 0, done_cnt = 0, wr_seen = 0, e_cyc = 0;
   logic mon_inv = 1'b0;
   logic [34:0] mon_e;
   vec_t mon_v;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         idx = 0;
      end else begin
         if (m_done) done_cnt++;
         if (m_wr_valid) begin
            wr_seen++;
            if (exp_q.size() == 0) check("wr_unexpected_valid", 32'(m_wr_valid), 32'd0);
            else begin
               mon_e = exp_q.pop_front();
               check("wr_due_cycle", cyc, mon_e[34:3]);
               check("wr_addr", 32'(m_wr_addr), 32'(mon_e[2:0]));
            end
         end else if (exp_q.size() > 0) begin
            mon_e = exp_q[0];
            if (mon_e[34:3] <= 32'(cyc)) begin
               check("wr_missing", 32'(m_wr_valid), 32'd1);
               void'(exp_q.pop_front());
            end
         end
         if (m_rd_valid) begin
            if (idx >= NREAD) check("rd_extra_valid", 32'(m_rd_valid), 32'd0);
            else begin
               mon_v = tab[mon_inv][idx];
               check("rd_addr", 32'(m_rd_addr), 32'(mon_v.rd));
               check("tw_addr", 32'(m_tw_addr), 32'(mon_v.tw));
               if (idx % 2 == 0) check("stage", 32'(m_stage), 32'(mon_v.stg));
               if (sel && idx % 8 == 0 && idx > 0) check("flush_gap_pending", exp_q.size(), 32'd0);
               exp_q.push_back({32'(cyc + PD), mon_v.rd});
               idx++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_outputs_zero();
      check("rst_rd_addr",  32'(m_rd_addr),  32'd0);
      check("rst_rd_valid", 32'(m_rd_valid), 32'd0);
      check("rst_tw_addr",  32'(m_tw_addr),  32'd0);
      check("rst_wr_addr",  32'(m_wr_addr),  32'd0);
      check("rst_wr_valid", 32'(m_wr_valid), 32'd0);
      check("rst_stage",    32'(m_stage),    32'd0);
      check("rst_busy",     32'(m_busy),     32'd0);
      check("rst_done",     32'(m_done),     32'd0);
      check("rst_state",    32'(m_state),    32'(ST_IDLE));
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((nf_busy || fl_busy) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check("idle_timeout", 32'(nf_busy | fl_busy), 32'd0);
   endtask

   task automatic launch(input logic inv);
      @(posedge clk);
      #1;
      idx = 0;
      mon_inv = inv;
      exp_q.delete();
      start = 1'b1;
      inverse = inv;
      @(posedge clk);
      #1;
      start = 1'b0;
      e_cyc = cyc;
      check("busy_after_start", 32'(m_busy), 32'd1);
   endtask

   task automatic wait_done(input int offset);
      int n = 0;
      while (!m_done && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!m_done) check("done_timeout", 32'(m_done), 32'd1);
      else begin
         if (offset >= 0) check("done_cycle", cyc, 32'(e_cyc + offset));
         check("busy_at_done", 32'(m_busy), 32'd0);
         check("reads_total", idx, 32'(NREAD));
         check("wr_pending_at_done", exp_q.size(), 32'd0);
      end
   endtask

   task automatic check_done_pulse();
      @(negedge clk);
      check("done_width", 32'(m_done), 32'd0);
      check("state_after_done", 32'(m_state), 32'(ST_IDLE));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int d0, w0, n;
      for (int i = 0; i < NREAD; i++) begin
         tab[0][i] = '{1'b0, 2'(i / 8), 3'(fwd_rd[i]), 3'(fwd_tw[i / 2])};
         tab[1][i] = '{1'b1, 2'(i / 8), 3'(inv_rd[i]), 3'(inv_tw[i / 2])};
      end
      rst = 1'b1; start = 1'b0; inverse = 1'b0; advance = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_outputs_zero();

      // forward, full rate, then inverse started in the done cycle
      sel = 1'b0; adv_mode = 0;
      launch(1'b0);
      wait_done(29);
      idx = 0; mon_inv = 1'b1; start = 1'b1; inverse = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; e_cyc = cyc;
      check("busy_b2b_start", 32'(m_busy), 32'd1);
      wait_done(29);
      check_done_pulse();

      // forward, random stalls
      wait_idle();
      adv_mode = 1;
      launch(1'b0);
      wait_done(-1);

      // stage flush, full rate
      wait_idle();
      sel = 1'b1; adv_mode = 0;
      launch(1'b0);
      wait_done(37);
      check_done_pulse();

      // stage flush, inverse, random stalls
      wait_idle();
      adv_mode = 1;
      launch(1'b1);
      wait_done(-1);

      // start and inverse wiggled mid-run must not disturb the run
      wait_idle();
      sel = 1'b0; adv_mode = 0;
      d0 = done_cnt;
      launch(1'b0);
      repeat (12) @(posedge clk);
      #1 start = 1'b1; inverse = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 inverse = 1'b0;
      @(posedge clk);
      #1 inverse = 1'b1;
      wait_done(29);
      repeat (10) @(negedge clk);
      check("single_done", done_cnt, 32'(d0 + 1));
      inverse = 1'b0;

      // reset in stage 1, then clean restart
      wait_idle();
      launch(1'b0);
      n = 0;
      while (idx < 11 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (n >= 200) check("reach_stage1", idx, 32'd11);
      #1 rst = 1'b1;
      @(negedge clk);
      check_outputs_zero();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      w0 = wr_seen;
      repeat (12) @(negedge clk);
      check("wr_after_reset", wr_seen, 32'(w0));
      wait_idle();
      launch(1'b0);
      wait_done(29);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
